// File: rtl/timer_irq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : timer_irq_unit
//  Description : Multi-channel programmable timer and interrupt source.
//                Each channel has a compare limit, auto-reload or one-shot
//                mode and a sticky pending flag (write 1 to clear). A global
//                prescaler divides the channel tick when the build macro
//                TIMER_PRESCALER_EN is defined; without it the tick fires
//                every cycle and address 0x80 is unmapped.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_irq_unit #(
    parameter int NUM_CHANNELS   = 2,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    resetActiveLow,
    input  logic [31:0]             axiWriteAddress,
    input  logic [31:0]             axiWriteData,
    input  logic                    axiWriteValid,
    input  logic [31:0]             axiReadAddress,
    output logic [31:0]             axiReadData,
    output logic [NUM_CHANNELS-1:0] irqPending,
    output logic                    timerInterrupt
);

    // Register offsets within a channel window, selected by address bits [3:2]
    localparam logic [1:0] c_regCtrl   = 2'd0;
    localparam logic [1:0] c_regLimit  = 2'd1;
    localparam logic [1:0] c_regCount  = 2'd2;
    localparam logic [1:0] c_regStatus = 2'd3;

    localparam logic [7:0]               c_prescaleAddr = 8'h80;
    localparam logic [COUNTER_WIDTH-1:0] c_countOne     = COUNTER_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [7:0]              w_wrOffset;
    logic [7:0]              w_rdOffset;
    logic                    w_wrChanWindow;
    logic [NUM_CHANNELS-1:0] w_ctrlWr;
    logic [NUM_CHANNELS-1:0] w_limitWr;
    logic [NUM_CHANNELS-1:0] w_countWr;
    logic [NUM_CHANNELS-1:0] w_statusWr;
    logic                    w_unusedBits;

    assign w_wrOffset = axiWriteAddress[7:0];
    assign w_rdOffset = axiReadAddress[7:0];

    // Only the low address byte is decoded; the rest is deliberately ignored.
    assign w_unusedBits = ^{axiWriteAddress[31:8], axiReadAddress[31:8], axiWriteData};

    // A channel window is the lower half of the map with word-aligned offsets.
    assign w_wrChanWindow = axiWriteValid && !w_wrOffset[7] && (w_wrOffset[1:0] == 2'b00);

    // Per-channel write strobes; channel numbers at or above NUM_CHANNELS never match
    always_comb begin
        w_ctrlWr   = '0;
        w_limitWr  = '0;
        w_countWr  = '0;
        w_statusWr = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (w_wrChanWindow && (int'(w_wrOffset[6:4]) == ch)) begin
                w_ctrlWr[ch]   = (w_wrOffset[3:2] == c_regCtrl);
                w_limitWr[ch]  = (w_wrOffset[3:2] == c_regLimit);
                w_countWr[ch]  = (w_wrOffset[3:2] == c_regCount);
                w_statusWr[ch] = (w_wrOffset[3:2] == c_regStatus);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------------
    logic w_tick;

`ifdef TIMER_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_prescaleCount;
    logic                      w_prescaleWr;

    assign w_prescaleWr = axiWriteValid && (w_wrOffset == c_prescaleAddr);
    assign w_tick       = (r_prescaleCount == r_prescale);

    // Prescaler counts 0..PRESCALE and restarts whenever PRESCALE is written
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            r_prescale      <= '0;
            r_prescaleCount <= '0;
        end else if (w_prescaleWr) begin
            r_prescale      <= axiWriteData[PRESCALE_WIDTH-1:0];
            r_prescaleCount <= '0;
        end else if (w_tick) begin
            r_prescaleCount <= '0;
        end else begin
            r_prescaleCount <= r_prescaleCount + PRESCALE_WIDTH'(1);
        end
    end
`else
    localparam int c_unusedPrescaleWidth = PRESCALE_WIDTH;

    assign w_tick = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Channel state
    // ------------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0]  r_enable;
    logic [NUM_CHANNELS-1:0]  r_autoReload;
    logic [NUM_CHANNELS-1:0]  r_irqEnable;
    logic [NUM_CHANNELS-1:0]  r_pending;
    logic [COUNTER_WIDTH-1:0] r_limit [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] r_count [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  w_match;

    // A channel matches on a tick once COUNT has reached or passed LIMIT
    always_comb begin
        w_match = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_match[ch] = r_enable[ch] && w_tick && (r_count[ch] >= r_limit[ch]);
        end
    end

    // Channel registers: software writes take priority, except that a new
    // match always sets pending and zeroes COUNT unless COUNT itself is written
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            r_enable     <= '0;
            r_autoReload <= '0;
            r_irqEnable  <= '0;
            r_pending    <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_limit[ch] <= '0;
                r_count[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                // Enable: a CTRL write wins over the one-shot auto-disable
                if (w_ctrlWr[ch]) begin
                    r_enable[ch]     <= axiWriteData[0];
                    r_autoReload[ch] <= axiWriteData[1];
                    r_irqEnable[ch]  <= axiWriteData[2];
                end else if (w_match[ch] && !r_autoReload[ch]) begin
                    r_enable[ch] <= 1'b0;
                end

                if (w_limitWr[ch]) begin
                    r_limit[ch] <= axiWriteData[COUNTER_WIDTH-1:0];
                end

                // COUNT: a software write suppresses that cycle's advance
                if (w_countWr[ch]) begin
                    r_count[ch] <= axiWriteData[COUNTER_WIDTH-1:0];
                end else if (w_match[ch]) begin
                    r_count[ch] <= '0;
                end else if (r_enable[ch] && w_tick) begin
                    r_count[ch] <= r_count[ch] + c_countOne;
                end

                // Pending: set beats a simultaneous write-1-to-clear
                if (w_match[ch]) begin
                    r_pending[ch] <= 1'b1;
                end else if (w_statusWr[ch] && axiWriteData[0]) begin
                    r_pending[ch] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read-back and interrupt outputs
    // ------------------------------------------------------------------------
    logic [31:0] w_rdLimit;
    logic [31:0] w_rdCount;

    // Combinational read mux; anything unmapped reads as zero
    always_comb begin
        axiReadData = '0;
        w_rdLimit   = '0;
        w_rdCount   = '0;
        if (!w_rdOffset[7] && (w_rdOffset[1:0] == 2'b00)) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (int'(w_rdOffset[6:4]) == ch) begin
                    w_rdLimit[COUNTER_WIDTH-1:0] = r_limit[ch];
                    w_rdCount[COUNTER_WIDTH-1:0] = r_count[ch];
                    case (w_rdOffset[3:2])
                        c_regCtrl:   axiReadData = {29'd0, r_irqEnable[ch], r_autoReload[ch], r_enable[ch]};
                        c_regLimit:  axiReadData = w_rdLimit;
                        c_regCount:  axiReadData = w_rdCount;
                        c_regStatus: axiReadData = {31'd0, r_pending[ch]};
                        default:     axiReadData = '0;
                    endcase
                end
            end
        end
`ifdef TIMER_PRESCALER_EN
        if (w_rdOffset == c_prescaleAddr) begin
            axiReadData[PRESCALE_WIDTH-1:0] = r_prescale;
        end
`endif
    end

    assign irqPending     = r_pending & r_irqEnable;
    assign timerInterrupt = |irqPending;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_irq_unit
//  Description : Directed self-checking bench for timer_irq_unit (default
//                parameters). Expected prescaled period follows whether
//                TIMER_PRESCALER_EN is defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_irq_unit;

`ifdef TIMER_PRESCALER_EN
    localparam logic [31:0] c_expPeriod   = 32'd6;
    localparam logic [31:0] c_expPrescale = 32'd2;
`else
    localparam logic [31:0] c_expPeriod   = 32'd2;
    localparam logic [31:0] c_expPrescale = 32'd0;
`endif

    logic        clock;
    logic        resetActiveLow;
    logic [31:0] axiWriteAddress;
    logic [31:0] axiWriteData;
    logic        axiWriteValid;
    logic [31:0] axiReadAddress;
    logic [31:0] axiReadData;
    logic [1:0]  irqPending;
    logic        timerInterrupt;

    int totalChecks = 0;
    int badChecks   = 0;

    timer_irq_unit dut (
        .clock          (clock),
        .resetActiveLow (resetActiveLow),
        .axiWriteAddress(axiWriteAddress),
        .axiWriteData   (axiWriteData),
        .axiWriteValid  (axiWriteValid),
        .axiReadAddress (axiReadAddress),
        .axiReadData    (axiReadData),
        .irqPending     (irqPending),
        .timerInterrupt (timerInterrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge: commits on the next rising edge, returns at the following falling edge
    task automatic regWrite(input logic [31:0] addr, input logic [31:0] data);
        axiWriteAddress = addr;
        axiWriteData    = data;
        axiWriteValid   = 1'b1;
        @(negedge clock);
        axiWriteValid   = 1'b0;
    endtask

    task automatic regRead(input logic [31:0] addr, output logic [31:0] data);
        axiReadAddress = addr;
        #1;
        data = axiReadData;
    endtask

    task automatic doReset();
        resetActiveLow = 1'b0;
        @(negedge clock);
        resetActiveLow = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] resetAddrs [9];
        int          expCount [4];
        int          waitCycles;
        logic        found;

        resetAddrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h80};
        expCount   = '{1, 2, 3, 0};

        axiWriteAddress = '0;
        axiWriteData    = '0;
        axiWriteValid   = 1'b0;
        axiReadAddress  = '0;
        resetActiveLow  = 1'b0;
        repeat (2) @(negedge clock);
        resetActiveLow  = 1'b1;
        @(negedge clock);

        // Reset state: every register reads 0
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            regRead(resetAddrs[i], rd);
            checkValue($sformatf("resetRead_%0h", resetAddrs[i]), rd, 32'd0);
        end
        checkValue("resetIrq", {31'd0, timerInterrupt}, 32'd0);

        // Unmapped channel and address: writes ignored, reads 0
        @(negedge clock);
        regWrite(32'h20, 32'hFF);
        regWrite(32'h84, 32'hFF);
        regRead(32'h20, rd);
        checkValue("unmappedChan2", rd, 32'd0);
        regRead(32'h84, rd);
        checkValue("unmapped84", rd, 32'd0);

        // Ch0 auto-reload LIMIT=3: COUNT 1,2,3,0 with pending on the fourth edge
        doReset();
        regWrite(32'h04, 32'd3);
        regWrite(32'h00, 32'h7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            regRead(32'h08, rd);
            checkValue($sformatf("ch0Count_%0d", k + 1), rd, 32'(expCount[k]));
            checkValue($sformatf("ch0Irq_%0d", k + 1), {31'd0, timerInterrupt}, (k == 3) ? 32'd1 : 32'd0);
        end
        // W1C on a non-match cycle clears
        regWrite(32'h0C, 32'd1);
        regRead(32'h0C, rd);
        checkValue("w1cClear", rd, 32'd0);
        checkValue("w1cClearIrq", {31'd0, timerInterrupt}, 32'd0);
        // Next match four cycles after the previous one
        repeat (3) @(negedge clock);
        regRead(32'h0C, rd);
        checkValue("ch0SecondMatch", rd, 32'd1);
        // W1C landing on a match edge leaves pending set
        repeat (3) @(negedge clock);
        regWrite(32'h0C, 32'd1);
        regRead(32'h0C, rd);
        checkValue("w1cOnMatch", rd, 32'd1);
        regRead(32'h08, rd);
        checkValue("w1cOnMatchCount", rd, 32'd0);

        // Asynchronous reset mid-count with pending set
        doReset();
        regWrite(32'h04, 32'd3);
        regWrite(32'h00, 32'h7);
        repeat (6) @(negedge clock);
        regRead(32'h08, rd);
        checkValue("preResetCount", rd, 32'd2);
        checkValue("preResetIrq", {31'd0, timerInterrupt}, 32'd1);
        resetActiveLow = 1'b0;
        #1;
        checkValue("asyncResetIrq", {31'd0, timerInterrupt}, 32'd0);
        regRead(32'h08, rd);
        checkValue("asyncResetCount", rd, 32'd0);
        regRead(32'h0C, rd);
        checkValue("asyncResetStatus", rd, 32'd0);
        @(negedge clock);
        resetActiveLow = 1'b1;
        @(negedge clock);

        // COUNT write during a tick wins; LIMIT below COUNT matches next tick
        regWrite(32'h04, 32'd100);
        regWrite(32'h00, 32'h1);
        repeat (2) @(negedge clock);
        regWrite(32'h08, 32'd7);
        regRead(32'h08, rd);
        checkValue("countWriteWins", rd, 32'd7);
        regWrite(32'h04, 32'd3);
        regRead(32'h08, rd);
        checkValue("countAfterLimitWr", rd, 32'd8);
        @(negedge clock);
        regRead(32'h08, rd);
        checkValue("limitBelowCount", rd, 32'd0);
        regRead(32'h0C, rd);
        checkValue("limitBelowStatus", rd, 32'd1);
        checkValue("irqMaskedOff", {31'd0, timerInterrupt}, 32'd0);

        // Ch1 one-shot LIMIT=5: pending six edges after enable, then disabled
        doReset();
        regWrite(32'h14, 32'd5);
        regWrite(32'h10, 32'h5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            checkValue($sformatf("oneShotPend_%0d", k), {30'd0, irqPending}, (k == 6) ? 32'd2 : 32'd0);
        end
        regRead(32'h10, rd);
        checkValue("oneShotCtrl", rd, 32'h4);
        repeat (2) @(negedge clock);
        regRead(32'h18, rd);
        checkValue("oneShotCountHeld", rd, 32'd0);
        regRead(32'h1C, rd);
        checkValue("oneShotSticky", rd, 32'd1);

        // Prescaled period: PRESCALE=2, LIMIT=1, auto-reload
        doReset();
        regWrite(32'h80, 32'd2);
        regWrite(32'h04, 32'd1);
        regWrite(32'h00, 32'h3);
        regRead(32'h80, rd);
        checkValue("prescaleRead", rd, c_expPrescale);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clock);
            regRead(32'h0C, rd);
            found = rd[0];
        end
        checkValue("prescaleFirstMatch", {31'd0, found}, 32'd1);
        regWrite(32'h0C, 32'd1);
        regRead(32'h0C, rd);
        checkValue("prescaleCleared", rd, 32'd0);
        found      = 1'b0;
        waitCycles = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clock);
            waitCycles++;
            regRead(32'h0C, rd);
            found = rd[0];
        end
        checkValue("prescaleSecondMatch", {31'd0, found}, 32'd1);
        checkValue("prescalePeriod", 32'(waitCycles + 1), c_expPeriod);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_irq_unit.md
# timer_irq_unit

Programmable multi-channel timer and interrupt source replacing the fixed free-running limit counter in the SoC top level. It adds per-channel compare limits, auto-reload or one-shot mode, sticky pending flags with write-1-to-clear, and an optional global prescaler. It sits as an IO slave behind the bus interconnect and drives the controller's `timerInterrupt` input.

## Interface
- `NUM_CHANNELS`, default 2: number of independent timer channels, legal range 1..8.
- `COUNTER_WIDTH`, default 32: width of the count and limit registers, legal range 8..32.
- `PRESCALE_WIDTH`, default 8: width of the global prescaler, legal range 1..16.

Ports:
- `clock`  in  1  single clock for all state.
- `resetActiveLow`  in  1  asynchronous, active-low reset.
- `axiWriteAddress`  in  32  byte address of the write; bits [7:0] are decoded, upper bits ignored.
- `axiWriteData`  in  32  write data.
- `axiWriteValid`  in  1  write strobe; commits at the rising edge.
- `axiReadAddress`  in  32  byte address of the read; bits [7:0] are decoded.
- `axiReadData`  out  32  combinational read data.
- `irqPending`  out  NUM_CHANNELS  per-channel pending AND irqEnable.
- `timerInterrupt`  out  1  OR reduction of `irqPending`.

## Operation
- Register map:
  - Channel n base is n*0x10.
  - +0x0 CTRL: bit0 enable, bit1 autoReload, bit2 irqEnable.
  - +0x4 LIMIT.
  - +0x8 COUNT: read/write.
  - +0xC STATUS: bit0 pending, write 1 to clear.
  - 0x80 PRESCALE.
- Unmapped addresses, and channels ≥ NUM_CHANNELS: reads return 0, writes are ignored. Unused upper bits read 0.
- Tick: the prescaler counter counts 0..PRESCALE. `tick` asserts in the cycle where prescaleCount == PRESCALE, and the prescaler wraps to 0 at that edge. PRESCALE=0 gives a tick every cycle.
- Per channel, at each edge where enable=1 and tick=1:
  - If COUNT >= LIMIT: COUNT←0 and pending←1. If autoReload=0, enable←0 (one-shot).
  - Otherwise: COUNT←COUNT+1, with modulo-2^COUNTER_WIDTH wrap.
- Period is (LIMIT+1)·(PRESCALE+1) cycles. LIMIT=0 sets pending on every tick.
- When enable=0, COUNT holds its value. Pending is sticky until cleared, regardless of enable.
- Writing CTRL with enable rising does not reset COUNT.
- Simultaneous events:
  - Software write to COUNT in a tick cycle: the write wins, with no increment that cycle.
  - W1C of pending in the same cycle as a new match: set wins, so pending stays 1.
  - Write of a LIMIT below the current COUNT: the next tick matches (>= compare); COUNT is not truncated.
  - Write to CTRL clearing enable in a match cycle: the write wins for enable. The match still sets pending and zeroes COUNT.
- Writing PRESCALE resets the prescaler counter to 0.

## Timing
- All outputs and registers reset to 0 asynchronously. The reset takes effect mid-count and drops pending immediately.
- Register writes are visible on `axiReadData` in the cycle after the commit edge. Reads have zero-cycle latency.
- Pending, `irqPending` and `timerInterrupt` go high directly after the match edge, with no extra pipeline stage. Software clear drops them after the write edge.
- With PRESCALE=0, a channel enabled at edge E0 with LIMIT=L sets pending at edge E0+L+1.

## Configuration
- `TIMER_PRESCALER_EN`:
  - Defined: the PRESCALE register and prescaler counter are present as described.
  - Undefined: tick is tied to 1. Address 0x80 reads 0 and ignores writes, and no prescaler flops are synthesised.

## Test plan
- Reset then read every register -> all read 0; `timerInterrupt`=0.
- Ch0: LIMIT=3, CTRL=0b111, PRESCALE=0 -> pending at enable-edge+4, again every 4 cycles; COUNT sequence 1,2,3,0.
- Ch1 one-shot: LIMIT=5, CTRL=0b101 -> pending at +6 cycles, CTRL bit0 reads 0 afterwards, COUNT stays 0.
- PRESCALE=2, ch0 LIMIT=1 auto-reload -> pending period 6 cycles; with the macro undefined, period 2 cycles.
- W1C to STATUS in the same cycle as a match -> pending remains 1. W1C on a non-match cycle -> 0 next cycle, `timerInterrupt` deasserts.
- Assert reset with COUNT=2 and pending=1 -> everything 0 immediately. Write COUNT=7 during a tick -> reads 7, not 8.
